// File: rtl/stopwatch_sched.sv
// Round-robin scheduler that lends one shared stopwatch timer to NUM_REQ clients
// and reports each client's elapsed count when its session ends with done.
module stopwatch_sched #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 16,
  parameter int MAX        = 99,
  localparam int IdW       = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NUM_REQ-1:0]    req,
  input  logic [NUM_REQ-1:0]    done,
  output logic [NUM_REQ-1:0]    grant,
  output logic                  tmr_reset,
  output logic                  tmr_start,
  output logic                  tmr_stop,
  input  logic [DATA_WIDTH-1:0] tmr_count,
  output logic                  result_valid,
  output logic [IdW-1:0]        result_id,
  output logic [DATA_WIDTH-1:0] result_count,
  output logic                  result_wrapped
);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] CLEAR  = 3'd1;
  localparam logic [2:0] ARM    = 3'd2;
  localparam logic [2:0] RUN    = 3'd3;
  localparam logic [2:0] HALT   = 3'd4;
  localparam logic [2:0] REPORT = 3'd5;

  localparam logic [DATA_WIDTH-1:0] MaxCount = DATA_WIDTH'(MAX);
  localparam logic [IdW-1:0]        LastId   = IdW'(NUM_REQ - 1);

  logic [2:0]            state_q, state_d;
  logic [IdW-1:0]        winner_q, winner_d;
  logic [IdW-1:0]        ptr_q, ptr_d;
  logic                  pending_q, pending_d;
  logic                  wrap_q, wrap_d;
  logic [IdW-1:0]        resId_q, resId_d;
  logic [DATA_WIDTH-1:0] resCount_q, resCount_d;
  logic                  resWrap_q, resWrap_d;
  logic [IdW-1:0]        rrWinner;

  // Rotate the request vector so the search always begins at bit 0 = ptr.
  function automatic logic [IdW-1:0] rrPick(input logic [NUM_REQ-1:0] reqVec,
                                           input logic [IdW-1:0] start);
    logic [NUM_REQ-1:0] rot;
    logic               found;
    int                 sum;
    logic [IdW-1:0]     pick;
    rot   = (reqVec >> start) | (reqVec << (NUM_REQ - int'(start)));
    found = 1'b0;
    pick  = start;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!found && rot[i]) begin
        found = 1'b1;
        sum   = int'(start) + i;
        if (sum >= NUM_REQ) sum = sum - NUM_REQ;
        pick  = IdW'(sum);
      end
    end
    return pick;
  endfunction

  assign rrWinner = rrPick(req, ptr_q);

  always_comb begin
    state_d    = state_q;
    winner_d   = winner_q;
    ptr_d      = ptr_q;
    pending_d  = pending_q;
    wrap_d     = wrap_q;
    resId_d    = resId_q;
    resCount_d = resCount_q;
    resWrap_d  = resWrap_q;
    case (state_q)
      IDLE: begin
        if (|req) begin
          winner_d = rrWinner;
          state_d  = CLEAR;
        end
      end
      CLEAR: begin
        wrap_d    = 1'b0;
        pending_d = 1'b0;
        state_d   = ARM;
      end
      ARM: state_d = RUN;
      RUN: begin
        if (tmr_count == MaxCount) wrap_d = 1'b1;
        // done takes priority over a simultaneous request drop
        if (done[winner_q]) begin
          pending_d = 1'b1;
          state_d   = HALT;
        end else if (!req[winner_q]) begin
          pending_d = 1'b0;
          state_d   = HALT;
        end
      end
      HALT: begin
        ptr_d = (winner_q == LastId) ? '0 : winner_q + 1'b1;
        if (pending_q) begin
          resId_d    = winner_q;
          resCount_d = tmr_count;
          resWrap_d  = wrap_q;
          state_d    = REPORT;
        end else begin
          state_d = IDLE;
        end
      end
      REPORT:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      winner_q   <= '0;
      ptr_q      <= '0;
      pending_q  <= 1'b0;
      wrap_q     <= 1'b0;
      resId_q    <= '0;
      resCount_q <= '0;
      resWrap_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      winner_q   <= winner_d;
      ptr_q      <= ptr_d;
      pending_q  <= pending_d;
      wrap_q     <= wrap_d;
      resId_q    <= resId_d;
      resCount_q <= resCount_d;
      resWrap_q  <= resWrap_d;
    end
  end

  // Outputs are gated by reset so they are quiet from the first reset cycle.
  always_comb begin
    grant = '0;
    if (!reset && state_q != IDLE) grant[winner_q] = 1'b1;
  end

  assign tmr_reset      = reset || (state_q == CLEAR);
  assign tmr_start      = !reset && (state_q == ARM);
  assign tmr_stop       = !reset && (state_q == HALT);
  assign result_valid   = !reset && (state_q == REPORT);
  assign result_id      = resId_q;
  assign result_count   = resCount_q;
  assign result_wrapped = resWrap_q;

endmodule

// File: tb/tb_stopwatch_sched.sv
// Randomized and directed bench for stopwatch_sched with a behavioural stopwatch
// timer attached; expectations come from session-level arithmetic.
module tb_stopwatch_sched;

  localparam int NR   = 4;
  localparam int DW   = 16;
  localparam int MAXV = 99;

  logic          clk = 1'b0;
  logic          reset;
  logic [NR-1:0] req;
  logic [NR-1:0] done;
  logic [NR-1:0] grant;
  logic          tmrReset, tmrStart, tmrStop;
  logic [DW-1:0] tmrCount;
  logic          resultValid;
  logic [1:0]    resultId;
  logic [DW-1:0] resultCount;
  logic          resultWrapped;

  int checks   = 0;
  int errors   = 0;
  int modelPtr = 0;

  logic [NR-1:0] sGrant, sGrantEnd;
  logic          sClear, sStart, sStop, sValid, sWrap, sValidAfter;
  logic [1:0]    sId;
  logic [DW-1:0] sCount;
  bit            sTimeout;

  logic          timerRun;

  stopwatch_sched #(.NUM_REQ(NR), .DATA_WIDTH(DW), .MAX(MAXV)) dut (
    .clk(clk), .reset(reset), .req(req), .done(done), .grant(grant),
    .tmr_reset(tmrReset), .tmr_start(tmrStart), .tmr_stop(tmrStop),
    .tmr_count(tmrCount), .result_valid(resultValid), .result_id(resultId),
    .result_count(resultCount), .result_wrapped(resultWrapped)
  );

  always #5 clk = ~clk;

  // Stopwatch timer: counts 0..MAX and wraps while running.
  always @(posedge clk) begin
    if (tmrReset) begin
      tmrCount <= '0;
      timerRun <= 1'b0;
    end else if (tmrStop) begin
      timerRun <= 1'b0;
    end else if (tmrStart || timerRun) begin
      timerRun <= 1'b1;
      tmrCount <= (tmrCount == DW'(MAXV)) ? '0 : tmrCount + 1'b1;
    end
  end

  function automatic int rrPick(input logic [NR-1:0] m, input int p);
    for (int i = 0; i < NR; i++)
      if (m[(p + i) % NR]) return (p + i) % NR;
    return -1;
  endfunction

  // mode 0: done in RUN k, mode 1: req drop in RUN k, mode 2: both at once.
  task automatic runSession(input logic [NR-1:0] mask, input int w, input int k,
                            input int mode, input logic [NR-1:0] foreign, input bit clearAfter);
    int n;
    sTimeout = 0; sGrant = '0; sGrantEnd = '0; sClear = 0; sStart = 0; sStop = 0;
    sValid = 0; sId = '0; sCount = '0; sWrap = 0; sValidAfter = 0;
    req = mask; done = '0; n = 0;
    do begin @(negedge clk); n++; end while (grant == '0 && n < 20);
    if (grant == '0) begin sTimeout = 1; req = '0; return; end
    sGrant = grant; sClear = tmrReset;
    @(negedge clk); sStart = tmrStart;
    for (int i = 1; i <= k; i++) begin
      @(negedge clk);
      if (i < k) done = foreign & ~(4'b0001 << w);
      else begin
        done = '0;
        if (mode != 1) done[w] = 1'b1;
        if (mode != 0) req[w] = 1'b0;
      end
    end
    @(negedge clk); done = '0; sStop = tmrStop;
    @(negedge clk);
    sValid = resultValid; sId = resultId; sCount = resultCount; sWrap = resultWrapped;
    sGrantEnd = grant; req[w] = 1'b0;
    if (mode != 1) begin @(negedge clk); sValidAfter = resultValid; end
    if (clearAfter) req = '0;
  endtask

  task automatic test_reset();
    reset = 1'b1; req = '0; done = '0;
    repeat (2) @(negedge clk);
    checks++; if (grant !== 4'b0000) begin errors++; $display("FAIL reset_grant got %b want 0000", grant); end
    checks++; if (tmrReset !== 1'b1) begin errors++; $display("FAIL reset_tmr_reset got %b want 1", tmrReset); end
    checks++; if (tmrStart !== 1'b0 || tmrStop !== 1'b0) begin errors++; $display("FAIL reset_start_stop got %b%b want 00", tmrStart, tmrStop); end
    checks++; if (resultValid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", resultValid); end
    checks++; if ({resultId, resultCount, resultWrapped} !== '0) begin errors++; $display("FAIL reset_results got id %0d cnt %0d wrap %b want 0 0 0", resultId, resultCount, resultWrapped); end
    reset = 1'b0; modelPtr = 0;
    @(negedge clk);
    checks++; if (tmrReset !== 1'b0 || grant !== 4'b0000) begin errors++; $display("FAIL idle_after_reset got tmr_reset %b grant %b want 0 0000", tmrReset, grant); end
  endtask

  task automatic test_round_robin();
    logic [NR-1:0] masks [3];
    int            ids   [3];
    masks[0] = 4'b1011; masks[1] = 4'b1010; masks[2] = 4'b1000;
    reset = 1'b1; req = 4'b1011; done = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0; modelPtr = 0;
    for (int s = 0; s < 3; s++) begin
      ids[s] = rrPick(masks[s], modelPtr);
      runSession(masks[s], ids[s], 2, 0, '0, s == 2);
      checks++; if (sTimeout || sGrant !== (4'b0001 << ids[s])) begin errors++; $display("FAIL rr_grant%0d got %b want %b", s, sGrant, 4'b0001 << ids[s]); end
      checks++; if (sValid !== 1'b1 || sCount !== 16'd3) begin errors++; $display("FAIL rr_count%0d got valid %b cnt %0d want 1 3", s, sValid, sCount); end
      modelPtr = (ids[s] + 1) % NR;
    end
  endtask

  task automatic test_single_session();
    int w;
    w = rrPick(4'b0100, modelPtr);
    runSession(4'b0100, w, 5, 0, '0, 1);
    checks++; if (sTimeout || sGrant !== 4'b0100) begin errors++; $display("FAIL single_grant got %b want 0100", sGrant); end
    checks++; if (sClear !== 1'b1 || sStart !== 1'b1) begin errors++; $display("FAIL single_clear_arm got %b%b want 11", sClear, sStart); end
    checks++; if (sStop !== 1'b1) begin errors++; $display("FAIL single_halt got %b want 1", sStop); end
    checks++; if (sValid !== 1'b1 || sId !== 2'd2 || sCount !== 16'd6 || sWrap !== 1'b0) begin errors++; $display("FAIL single_result got v%b id%0d cnt%0d wr%b want v1 id2 cnt6 wr0", sValid, sId, sCount, sWrap); end
    checks++; if (sValidAfter !== 1'b0) begin errors++; $display("FAIL single_valid_one_cycle got %b want 0", sValidAfter); end
    modelPtr = (w + 1) % NR;
    w = rrPick(4'b1111, modelPtr);
    runSession(4'b1111, w, 1, 0, '0, 1);
    checks++; if (sTimeout || sGrant !== (4'b0001 << w)) begin errors++; $display("FAIL single_ptr_grant got %b want %b", sGrant, 4'b0001 << w); end
    checks++; if (sCount !== 16'd2 || sId !== 2'(w)) begin errors++; $display("FAIL single_ptr_result got id%0d cnt%0d want id%0d cnt2", sId, sCount, w); end
    modelPtr = (w + 1) % NR;
  endtask

  task automatic test_abort();
    logic [DW-1:0] heldCount;
    int w;
    heldCount = resultCount;
    runSession(4'b0010, 1, 3, 1, '0, 1);
    checks++; if (sTimeout || sStop !== 1'b1) begin errors++; $display("FAIL abort_halt got %b want 1", sStop); end
    checks++; if (sValid !== 1'b0 || sGrantEnd !== 4'b0000) begin errors++; $display("FAIL abort_no_result got valid %b grant %b want 0 0000", sValid, sGrantEnd); end
    checks++; if (sCount !== heldCount) begin errors++; $display("FAIL abort_hold got %0d want %0d", sCount, heldCount); end
    modelPtr = 2;
    w = rrPick(4'b0110, modelPtr);
    runSession(4'b0110, w, 1, 0, '0, 1);
    checks++; if (sTimeout || sGrant !== (4'b0001 << w)) begin errors++; $display("FAIL abort_ptr_grant got %b want %b", sGrant, 4'b0001 << w); end
    modelPtr = (w + 1) % NR;
  endtask

  task automatic test_wrap();
    int ks [3];
    ks[0] = 120; ks[1] = 98; ks[2] = 99;
    for (int s = 0; s < 3; s++) begin
      runSession(4'b0001, 0, ks[s], 0, '0, 1);
      checks++; if (sTimeout || sValid !== 1'b1 || sCount !== DW'((ks[s] + 1) % (MAXV + 1))) begin errors++; $display("FAIL wrap_count k%0d got %0d want %0d", ks[s], sCount, (ks[s] + 1) % (MAXV + 1)); end
      checks++; if (sWrap !== (ks[s] >= MAXV)) begin errors++; $display("FAIL wrap_flag k%0d got %b want %b", ks[s], sWrap, ks[s] >= MAXV); end
    end
    modelPtr = 1;
  endtask

  task automatic test_foreign_done();
    runSession(4'b0001, 0, 6, 0, 4'b1000, 1);
    checks++; if (sTimeout || sValid !== 1'b1 || sId !== 2'd0 || sCount !== 16'd7) begin errors++; $display("FAIL foreign_done got v%b id%0d cnt%0d want v1 id0 cnt7", sValid, sId, sCount); end
    modelPtr = 1;
  endtask

  task automatic test_reset_mid();
    int w, n;
    w = rrPick(4'b0100, modelPtr);
    runSession(4'b0100, w, 1, 0, '0, 1);
    modelPtr = (w + 1) % NR;
    w = rrPick(4'b0001, modelPtr);
    req = 4'b0001; n = 0;
    do begin @(negedge clk); n++; end while (grant == '0 && n < 20);
    checks++; if (grant !== (4'b0001 << w)) begin errors++; $display("FAIL midreset_grant got %b want %b", grant, 4'b0001 << w); end
    repeat (5) @(negedge clk);
    reset = 1'b1; req = 4'b1010;
    @(negedge clk);
    checks++; if (grant !== 4'b0000 || tmrReset !== 1'b1 || resultValid !== 1'b0) begin errors++; $display("FAIL midreset_quiet got grant %b tmr_reset %b valid %b want 0000 1 0", grant, tmrReset, resultValid); end
    @(negedge clk);
    checks++; if (tmrReset !== 1'b1 || tmrStop !== 1'b0) begin errors++; $display("FAIL midreset_hold got tmr_reset %b stop %b want 1 0", tmrReset, tmrStop); end
    reset = 1'b0; modelPtr = 0;
    w = rrPick(4'b1010, modelPtr);
    runSession(4'b1010, w, 2, 0, '0, 1);
    checks++; if (sTimeout || sGrant !== (4'b0001 << w) || sCount !== 16'd3) begin errors++; $display("FAIL midreset_after got grant %b cnt %0d want %b 3", sGrant, sCount, 4'b0001 << w); end
    modelPtr = (w + 1) % NR;
  endtask

  task automatic test_random();
    logic [NR-1:0] mask, foreign;
    logic [DW-1:0] lastCount;
    bit            haveLast;
    int            w, k, mode, r;
    haveLast = 0; lastCount = '0;
    for (int it = 0; it < 40; it++) begin
      mask    = NR'($urandom_range(1, 15));
      foreign = NR'($urandom_range(0, 15));
      w = rrPick(mask, modelPtr);
      k = ($urandom_range(0, 7) == 0) ? int'($urandom_range(95, 125)) : int'($urandom_range(1, 10));
      r = int'($urandom_range(0, 3));
      mode = (r == 3) ? 2 : ((r == 2) ? 1 : 0);
      runSession(mask, w, k, mode, foreign, 1);
      checks++; if (sTimeout || sGrant !== (4'b0001 << w)) begin errors++; $display("FAIL rand%0d_grant got %b want %b", it, sGrant, 4'b0001 << w); end
      checks++; if (sStop !== 1'b1 || sValid !== (mode != 1)) begin errors++; $display("FAIL rand%0d_end got stop %b valid %b want 1 %b", it, sStop, sValid, mode != 1); end
      if (mode != 1) begin
        checks++; if (sId !== 2'(w) || sCount !== DW'((k + 1) % (MAXV + 1)) || sWrap !== (k >= MAXV)) begin errors++; $display("FAIL rand%0d_result got id%0d cnt%0d wr%b want id%0d cnt%0d wr%b", it, sId, sCount, sWrap, w, (k + 1) % (MAXV + 1), k >= MAXV); end
        lastCount = DW'((k + 1) % (MAXV + 1)); haveLast = 1;
      end else if (haveLast) begin
        checks++; if (sCount !== lastCount) begin errors++; $display("FAIL rand%0d_hold got %0d want %0d", it, sCount, lastCount); end
      end
      modelPtr = (w + 1) % NR;
    end
  endtask

  initial begin
    reset = 1'b1; req = '0; done = '0;
    test_reset();
    test_round_robin();
    test_single_session();
    test_abort();
    test_wrap();
    test_foreign_done();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
